// File: rtl/simple_top_parity_pkg.sv
// simple_top_parity_pkg: channel indices, fault-injection FSM states and default sizes for the parity controller
package simple_top_parity_pkg;
  localparam int NCH_DEF = 4;
  localparam int FI_TIMEOUT_DEF = 15;
  localparam int CH_WADDR = 0;
  localparam int CH_WDATA = 1;
  localparam int CH_RADDR = 2;
  localparam int CH_RDATA = 3;
  typedef enum logic [1:0] {IDLE, INJECT, WAIT_DET, DONE} fi_state_e;
endpackage

// File: rtl/simple_top_parity_ctrl_if.sv
// simple_top_parity_ctrl_if: fault-injection request handshake
//   master drives FI_REQ (held until FI_ACK), FI_CH, FI_LEN; slave returns the one-cycle FI_ACK
interface simple_top_parity_ctrl_if;
  logic       FI_REQ;
  logic [1:0] FI_CH;
  logic [3:0] FI_LEN;
  logic       FI_ACK;
  modport master (output FI_REQ, FI_CH, FI_LEN, input FI_ACK);
  modport slave  (input FI_REQ, FI_CH, FI_LEN, output FI_ACK);
endinterface

// File: rtl/simple_top_parity_fi_seq.sv
// simple_top_parity_fi_seq: fault-injection sequencer (inject strobe, detection wait, pass/fail)
//   ACLK/RESETN_ACLK clock and async active-low reset; fi handshake slave
//   CFG_EN/ERR_IN channel enables and raw errors; FIERR inject strobes
//   fi_mask one-hot of the channel under test while busy; FI_BUSY/FI_PASS/FI_FAIL status
module simple_top_parity_fi_seq
  import simple_top_parity_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int FI_TIMEOUT = FI_TIMEOUT_DEF
) (
  input  logic           ACLK,
  input  logic           RESETN_ACLK,
  simple_top_parity_ctrl_if.slave fi,
  input  logic [NCH-1:0] CFG_EN,
  input  logic [NCH-1:0] ERR_IN,
  output logic [NCH-1:0] FIERR,
  output logic [NCH-1:0] fi_mask,
  output logic           FI_BUSY,
  output logic           FI_PASS,
  output logic           FI_FAIL
);
  localparam int TW = $clog2(FI_TIMEOUT + 1);
  localparam int CW = TW > 4 ? TW : 4;
  fi_state_e state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] fierr_q, fierr_d, ch_oh, req_oh;
  logic pass_q, pass_d, fail_q, fail_d, det;
  assign ch_oh = NCH'(1) << ch_q;
  assign req_oh = NCH'(1) << fi.FI_CH;
  assign fi.FI_ACK = state_q == IDLE && fi.FI_REQ;
  assign det = (state_q == INJECT || state_q == WAIT_DET) && |(ERR_IN & ch_oh);
  // pass_q doubles as the "already detected" flag so an early detection
  // during INJECT still lets the remaining inject cycles run to completion
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    fierr_d = fierr_q;
    pass_d = pass_q || det;
    fail_d = fail_q;
    case (state_q)
      IDLE: if (fi.FI_REQ) begin
        ch_d = fi.FI_CH;
        pass_d = 1'b0;
        fail_d = ~|(CFG_EN & req_oh);
        state_d = fail_d ? DONE : INJECT;
        cnt_d = CW'(fi.FI_LEN);
        fierr_d = fail_d ? '0 : req_oh;
      end
      INJECT: if (cnt_q == '0) begin
        fierr_d = '0;
        cnt_d = CW'(FI_TIMEOUT);
        state_d = pass_d ? DONE : WAIT_DET;
      end else cnt_d = cnt_q - 1'b1;
      WAIT_DET: begin
        cnt_d = cnt_q - 1'b1;
        fail_d = !pass_d && cnt_q <= CW'(1);
        state_d = (pass_d || fail_d) ? DONE : WAIT_DET;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge RESETN_ACLK)
    if (!RESETN_ACLK) begin
      state_q <= IDLE;
      ch_q <= '0;
      cnt_q <= '0;
      fierr_q <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      fierr_q <= fierr_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  assign FIERR = fierr_q;
  assign FI_BUSY = state_q != IDLE;
  assign FI_PASS = pass_q;
  assign FI_FAIL = fail_q;
  assign fi_mask = FI_BUSY ? ch_oh : '0;
endmodule

// File: rtl/simple_top_parity_ctrl.sv
// simple_top_parity_ctrl: parity checker enables, fault-injection control and functional error capture
//   ACLK/RESETN_ACLK clock and async active-low reset; fi fault-injection handshake slave
//   CFG_EN/ERR_IN/ERR_CLR per-channel enable, raw error, write-1-to-clear
//   ENERR/FIERR checker enables and inject strobes; ERR_STICKY/ERR_CNT captured errors
//   FI_BUSY/FI_PASS/FI_FAIL injection status; IRQ registered OR of sticky errors and FI_FAIL
module simple_top_parity_ctrl
  import simple_top_parity_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int FI_TIMEOUT = FI_TIMEOUT_DEF
) (
  input  logic           ACLK,
  input  logic           RESETN_ACLK,
  input  logic [NCH-1:0] CFG_EN,
  input  logic [NCH-1:0] ERR_IN,
  input  logic [NCH-1:0] ERR_CLR,
  simple_top_parity_ctrl_if.slave fi,
  output logic [NCH-1:0] ENERR,
  output logic [NCH-1:0] FIERR,
  output logic [NCH-1:0] ERR_STICKY,
  output logic [7:0]     ERR_CNT,
  output logic           FI_BUSY,
  output logic           FI_PASS,
  output logic           FI_FAIL,
  output logic           IRQ
);
  logic [NCH-1:0] enerr_q, sticky_q, sticky_d, fi_mask, fe;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] sum;
  logic irq_q, irq_d;
  simple_top_parity_fi_seq #(.NCH(NCH), .FI_TIMEOUT(FI_TIMEOUT)) u_fi_seq (
    .ACLK(ACLK),
    .RESETN_ACLK(RESETN_ACLK),
    .fi(fi),
    .CFG_EN(CFG_EN),
    .ERR_IN(ERR_IN),
    .FIERR(FIERR),
    .fi_mask(fi_mask),
    .FI_BUSY(FI_BUSY),
    .FI_PASS(FI_PASS),
    .FI_FAIL(FI_FAIL)
  );
  // the channel under injection is excluded so its expected error is not counted as functional
  always_comb begin
    fe = ERR_IN & CFG_EN & ~fi_mask;
    sticky_d = (sticky_q & ~ERR_CLR) | fe;
    sum = {1'b0, cnt_q} + 9'($countones(fe));
    cnt_d = sum[8] ? 8'hFF : sum[7:0];
    irq_d = |sticky_q || FI_FAIL;
  end
  always_ff @(posedge ACLK or negedge RESETN_ACLK)
    if (!RESETN_ACLK) begin
      enerr_q <= '0;
      sticky_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      enerr_q <= CFG_EN;
      sticky_q <= sticky_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  assign ENERR = enerr_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT = cnt_q;
  assign IRQ = irq_q;
endmodule

// File: tb/tb_simple_top_parity_ctrl.sv
// tb_simple_top_parity_ctrl: randomized scoreboard bench for the parity controller
module tb_simple_top_parity_ctrl;
  import simple_top_parity_pkg::*;
  localparam int T = FI_TIMEOUT_DEF;
  logic ACLK = 0, RESETN_ACLK = 0;
  logic [3:0] CFG_EN = 0, ERR_IN = 0, ERR_CLR = 0;
  logic [3:0] ENERR, FIERR, ERR_STICKY;
  logic [7:0] ERR_CNT;
  logic FI_BUSY, FI_PASS, FI_FAIL, IRQ;
  simple_top_parity_ctrl_if fi();
  simple_top_parity_ctrl #(.NCH(4), .FI_TIMEOUT(T)) dut (
    .ACLK(ACLK), .RESETN_ACLK(RESETN_ACLK), .CFG_EN(CFG_EN), .ERR_IN(ERR_IN), .ERR_CLR(ERR_CLR),
    .fi(fi), .ENERR(ENERR), .FIERR(FIERR), .ERR_STICKY(ERR_STICKY), .ERR_CNT(ERR_CNT),
    .FI_BUSY(FI_BUSY), .FI_PASS(FI_PASS), .FI_FAIL(FI_FAIL), .IRQ(IRQ)
  );
  always #5 ACLK = ~ACLK;
  typedef struct packed {logic [3:0] enerr, fierr, sticky; logic [7:0] cnt; logic busy, pass, fail, irq;} st_t;
  typedef struct packed {logic pass, fail; logic [4:0] ninj;} res_t;
  st_t st_q[$];
  logic ack_q[$];
  res_t res_q[$];
  int errs = 0, checks = 0;
  st_t m;
  int fk = -1, fch = 0, flen = 0, fd = -1, fb = 0, pend_d = -1, ninj = 0;
  bit fen = 0, fdet = 0, prev_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ACLK) begin : mon
    st_t e;
    res_t r;
    if (!RESETN_ACLK) begin
      prev_busy = 0;
      ninj = 0;
    end else begin
      if (ack_q.size() > 0) chk("FI_ACK", 32'(fi.FI_ACK), 32'(ack_q.pop_front()));
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("ENERR", 32'(ENERR), 32'(e.enerr));
        chk("FIERR", 32'(FIERR), 32'(e.fierr));
        chk("ERR_STICKY", 32'(ERR_STICKY), 32'(e.sticky));
        chk("ERR_CNT", 32'(ERR_CNT), 32'(e.cnt));
        chk("FI_BUSY", 32'(FI_BUSY), 32'(e.busy));
        chk("FI_PASS", 32'(FI_PASS), 32'(e.pass));
        chk("FI_FAIL", 32'(FI_FAIL), 32'(e.fail));
        chk("IRQ", 32'(IRQ), 32'(e.irq));
      end
      if (FIERR != 0) ninj++;
      if (prev_busy && !FI_BUSY) begin
        if (res_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL fi_done: completion seen with no request pending at %0t", $time);
        end else begin
          r = res_q.pop_front();
          chk("fi_result_pass", 32'(FI_PASS), 32'(r.pass));
          chk("fi_result_fail", 32'(FI_FAIL), 32'(r.fail));
          chk("fi_inject_cycles", 32'(ninj), 32'(r.ninj));
        end
        ninj = 0;
      end
      prev_busy = FI_BUSY;
    end
  end

  // one clock of the reference model: inputs are already driven for this cycle
  task automatic tick();
    st_t n;
    res_t r;
    bit acc;
    logic [3:0] fe;
    int s;
    acc = fi.FI_REQ && !m.busy;
    ack_q.push_back(acc);
    fe = ERR_IN & CFG_EN & ~(m.busy ? 4'(1 << fch) : 4'b0);
    s = int'(m.cnt) + $countones(fe);
    n = m;
    n.enerr = CFG_EN;
    n.sticky = (m.sticky & ~ERR_CLR) | fe;
    n.cnt = s > 255 ? 8'hFF : 8'(s);
    n.irq = |m.sticky | m.fail;
    if (acc) begin
      fk = 0;
      fch = int'(fi.FI_CH);
      flen = int'(fi.FI_LEN);
      fen = CFG_EN[fch];
      fd = pend_d;
      fdet = fen && fd >= 0 && fd <= flen + T;
      fb = !fen ? 1 : (fdet ? (fd > flen ? fd : flen) : flen + T) + 2;
      r.pass = fdet;
      r.fail = !fdet;
      r.ninj = 5'(fen ? flen + 1 : 0);
      res_q.push_back(r);
    end
    if (fk >= 0) begin
      fk++;
      n.busy = fk <= fb;
      n.fierr = (fen && fk <= flen + 1) ? 4'(1 << fch) : 4'b0;
      n.pass = fdet && fk >= fd + 2;
      n.fail = !fdet && fk >= fb;
    end
    @(posedge ACLK);
    st_q.push_back(n);
    m = n;
    #1;
  endtask

  task automatic idle(input int cycles, input bit rnd);
    fi.FI_REQ = 0;
    for (int i = 0; i < cycles; i++) begin
      ERR_IN = rnd ? 4'($urandom) : 4'b0;
      ERR_CLR = rnd ? 4'($urandom) : 4'b0;
      if (rnd && $urandom_range(0, 5) == 0) CFG_EN = 4'($urandom);
      tick();
    end
    ERR_IN = 0;
    ERR_CLR = 0;
  endtask

  task automatic run_fi(input int ch, input int len, input int d, input bit hold, input bit rnd);
    int guard = 0;
    fi.FI_REQ = 1;
    fi.FI_CH = 2'(ch);
    fi.FI_LEN = 4'(len);
    pend_d = d;
    ERR_IN = rnd ? 4'($urandom) & ~4'(1 << ch) : 4'b0;
    ERR_CLR = rnd ? 4'($urandom) : 4'b0;
    tick();
    while (m.busy && guard < 100) begin
      guard++;
      ERR_IN = rnd ? 4'($urandom) & ~4'(1 << ch) : 4'b0;
      ERR_CLR = rnd ? 4'($urandom) : 4'b0;
      if (rnd && $urandom_range(0, 7) == 0) CFG_EN = 4'($urandom);
      if (rnd) begin
        fi.FI_CH = 2'($urandom);
        fi.FI_LEN = 4'($urandom);
      end
      if (fdet && fk == fd + 1) ERR_IN[ch] = 1'b1;
      fi.FI_REQ = hold;
      tick();
    end
    fi.FI_REQ = 0;
    ERR_IN = 0;
    ERR_CLR = 0;
  endtask

  task automatic do_reset(input logic [3:0] cfg);
    RESETN_ACLK = 0;
    #1;
    st_q.delete();
    ack_q.delete();
    res_q.delete();
    m = '0;
    fk = -1;
    fen = 0;
    fdet = 0;
    fi.FI_REQ = 0;
    ERR_IN = 0;
    ERR_CLR = 0;
    CFG_EN = cfg;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_ENERR", 32'(ENERR), 0);
    chk("rst_FIERR", 32'(FIERR), 0);
    chk("rst_ERR_STICKY", 32'(ERR_STICKY), 0);
    chk("rst_ERR_CNT", 32'(ERR_CNT), 0);
    chk("rst_FI_BUSY", 32'(FI_BUSY), 0);
    chk("rst_FI_PASS", 32'(FI_PASS), 0);
    chk("rst_FI_FAIL", 32'(FI_FAIL), 0);
    chk("rst_IRQ", 32'(IRQ), 0);
    chk("rst_FI_ACK", 32'(fi.FI_ACK), 0);
    RESETN_ACLK = 1;
  endtask

  initial begin
    int len;
    fi.FI_REQ = 0;
    fi.FI_CH = 0;
    fi.FI_LEN = 0;
    m = '0;
    do_reset(4'hF);
    idle(2, 0);
    run_fi(CH_WDATA, 2, 2, 0, 0);
    idle(2, 0);
    run_fi(CH_RDATA, 0, -1, 0, 0);
    idle(2, 0);
    ERR_IN = 4'b0101;
    tick();
    ERR_IN = 4'b0001;
    ERR_CLR = 4'b0001;
    tick();
    idle(2, 0);
    ERR_IN = 4'hF;
    repeat (70) tick();
    idle(1, 0);
    CFG_EN = 4'b1011;
    run_fi(CH_RADDR, 3, 1, 0, 0);
    idle(2, 0);
    CFG_EN = 4'hF;
    run_fi(CH_WADDR, 1, 4, 1, 0);
    idle(1, 0);
    do_reset(4'hF);
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 3), 1);
      len = $urandom_range(0, 15);
      run_fi($urandom_range(0, 3), len, $urandom_range(0, len + T + 4) - 1, 1'($urandom_range(0, 1)), 1);
    end
    idle(3, 0);
    CFG_EN = 4'hF;
    idle(1, 0);
    fi.FI_REQ = 1;
    fi.FI_CH = 2'(CH_RADDR);
    fi.FI_LEN = 4'd10;
    pend_d = -1;
    tick();
    fi.FI_REQ = 0;
    repeat (3) tick();
    chk("FIERR_mid_inject", 32'(FIERR), 32'h4);
    RESETN_ACLK = 0;
    #1;
    chk("FIERR_async_reset", 32'(FIERR), 0);
    chk("FI_BUSY_async_reset", 32'(FI_BUSY), 0);
    chk("FI_PASS_FAIL_async_reset", 32'({FI_PASS, FI_FAIL}), 0);
    do_reset(4'hF);
    idle(3, 0);
    chk("fi_results_drained", 32'(res_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/simple_top_parity_ctrl.md
SIMPLE_TOP_PARITY_CTRL -- requirements
Module: simple_top_parity_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of parity-protected channels; bit order is 0=WADDR, 1=WDATA, 2=RADDR, 3=RDATA.
REQ-002 Parameter FI_TIMEOUT, default 15, maximum number of detection-wait cycles after a fault injection.
REQ-003 ACLK  input  1  clock; all logic on the rising edge.
REQ-004 RESETN_ACLK  input  1  reset, asynchronous, active-low.
REQ-005 CFG_EN  input  NCH  per-channel error-reporting enable.
REQ-006 ERR_IN  input  NCH  raw per-channel error pulses from the parity checkers, valid one per cycle.
REQ-007 ERR_CLR  input  NCH  write-1-to-clear pulses for the sticky error bits.
REQ-008 FI_REQ  input  1  fault-injection request, held until FI_ACK.
REQ-009 FI_CH  input  2  channel index to inject; sampled when FI_REQ and FI_ACK are both high.
REQ-010 FI_LEN  input  4  injection length minus one, in cycles; sampled with FI_CH.
REQ-011 FI_ACK  output  1  request accepted; a one-cycle pulse.
REQ-012 ENERR  output  NCH  enable for each parity checker; drives the ENERR_* pins.
REQ-013 FIERR  output  NCH  fault-inject strobe for each parity generator; drives the FIERR_* pins.
REQ-014 ERR_STICKY  output  NCH  latched functional errors.
REQ-015 ERR_CNT  output  8  saturating count of functional errors.
REQ-016 FI_BUSY  output  1  fault-injection sequence in progress.
REQ-017 FI_PASS  output  1  last injection was detected; sticky until the next accepted request.
REQ-018 FI_FAIL  output  1  last injection was not detected within FI_TIMEOUT; sticky until the next accepted request.
REQ-019 IRQ  output  1  registered OR of all ERR_STICKY bits and FI_FAIL.

Function
REQ-020 ENERR: registered copy of CFG_EN; one cycle of latency.
REQ-021 State machine states: IDLE, INJECT, WAIT_DET, DONE.
REQ-022 IDLE -> INJECT on FI_REQ.
  - FI_ACK pulses in the same cycle.
  - FI_CH and FI_LEN are latched.
  - FI_PASS and FI_FAIL are cleared.
  - If CFG_EN[FI_CH] is 0: FI_ACK still pulses, no injection occurs, the sequence goes IDLE -> DONE, and FI_FAIL is set.
REQ-023 INJECT: FIERR[ch] is high for exactly FI_LEN+1 consecutive cycles, starting the cycle after FI_ACK; all other FIERR bits stay 0.
REQ-024 INJECT -> WAIT_DET after the last inject cycle; the wait counter loads FI_TIMEOUT.
REQ-025 ERR_IN[ch] high during INJECT or WAIT_DET sets FI_PASS.
  - The sequence goes to DONE the next cycle.
  - If the detection comes during INJECT, the remaining inject cycles still complete before DONE.
REQ-026 WAIT_DET: the counter decrements every cycle; if it reaches 0 without detection, FI_FAIL is set and the sequence goes to DONE.
REQ-027 DONE -> IDLE after one cycle; FI_BUSY is high in INJECT, WAIT_DET and DONE.
REQ-028 FI_REQ is ignored while FI_BUSY; no FI_ACK is given then.
REQ-029 Functional error on channel i: ERR_IN[i] and CFG_EN[i], excluding channel ch while FI_BUSY.
  - It sets ERR_STICKY[i] the next cycle.
  - It increments ERR_CNT by the number of channels erroring in that cycle.
  - ERR_CNT saturates at 255 and never wraps.
REQ-030 ERR_CLR[i] clears ERR_STICKY[i]; a simultaneous set on the same bit wins over the clear.
REQ-031 ERR_CNT clears only on reset.
REQ-032 A CFG_EN[ch] change during an injection does not abort the sequence.

Reset
REQ-033 Asynchronous assert on RESETN_ACLK low; synchronous deassert is handled externally.
REQ-034 Reset values:
  - state: IDLE.
  - Outputs: all 0, i.e. ENERR, FIERR, ERR_STICKY, ERR_CNT, FI_ACK, FI_BUSY, FI_PASS, FI_FAIL, IRQ.
  - Counters: 0.
REQ-035 Reset mid-injection drops FIERR immediately, with no partial result.

Structure
REQ-036 Shared package simple_top_parity_pkg holds:
  - the channel index constants CH_WADDR, CH_WDATA, CH_RADDR, CH_RDATA;
  - the FSM state enum;
  - the default NCH and FI_TIMEOUT values.
REQ-037 One sub-module, simple_top_parity_fi_seq, contains the FSM and the inject/wait counters; the top level holds the sticky bits, the counter and IRQ.

Verification
REQ-038 Reset release with CFG_EN=4'hF, then the next cycle: ENERR=4'hF; every other output is 0.
REQ-039 FI_REQ, FI_CH=1, FI_LEN=2; ERR_IN[1] pulses 2 cycles after the first inject cycle:
  - FIERR = 4'b0010 for 3 cycles;
  - FI_PASS=1, FI_FAIL=0;
  - ERR_STICKY and ERR_CNT unchanged.
REQ-040 FI_REQ, FI_CH=3, FI_LEN=0, no ERR_IN: FIERR[3] is high for 1 cycle, then FI_FAIL=1 and IRQ=1 after 15 wait cycles.
REQ-041 ERR_IN=4'b0101 for 1 cycle with CFG_EN=4'hF, then ERR_CLR=4'b0001 in the same cycle as a new ERR_IN[0] pulse:
  - ERR_STICKY=4'b0101 after the first cycle;
  - ERR_CNT=2, then 3;
  - ERR_STICKY[0] stays 1.
REQ-042 ERR_IN=4'hF for 70 cycles with CFG_EN=4'hF: ERR_CNT saturates at 255.
REQ-043 Injection with CFG_EN[2]=0: FIERR stays 0 and FI_FAIL=1. Reset asserted mid-INJECT: FIERR=0 immediately.
